seven_segment_mux_counter: RTL and testbench

SEVEN_SEGMENT_MUX_COUNTER -- requirements
Module: seven_segment_mux_counter

---
 rtl/seven_seg_pkg.sv | 17 +
 rtl/seven_seg_decode.sv | 18 +
 rtl/seven_segment_mux_counter.sv | 136 +++++++++++++
 tb/tb_seven_segment_mux_counter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment counter: BCD digit width, segment
// width and the BCD-to-segment lookup table (bit0 = a .. bit6 = g).
package seven_seg_pkg;

    localparam int BCD_W       = 4;
    localparam int SEG_W       = 7;
    localparam int NUM_SYMBOLS = 10;

    typedef logic [BCD_W-1:0] bcd_t;
    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_TABLE [NUM_SYMBOLS] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational BCD-to-segment decoder; codes above 9 blank the display.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    output logic [SEG_W-1:0] o_seg
);

    // NOTE: every output of a combinational block gets a default first,
    // otherwise the untaken branch infers a latch.
    always_comb begin
        o_seg = '0;
        if (i_bcd < BCD_W'(NUM_SYMBOLS)) begin
            o_seg = SEG_TABLE[i_bcd];
        end
    end

endmodule

// File: rtl/seven_segment_mux_counter.sv
// Prescaled BCD up/down counter with a multiplexed seven-segment display
// driver. The prescaler period is programmable at run time.
module seven_segment_mux_counter
    import seven_seg_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int CMP_WIDTH       = 24,
    parameter int DEFAULT_COMPARE = 10_000_000,
    parameter int SCAN_DIV        = 10
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      count_down,
    input  logic                      clear,
    input  logic                      update_compare,
    input  logic [CMP_WIDTH-1:0]      compare_in,
    output logic [SEG_W-1:0]          led_out,
    output logic [DIGITS-1:0]         digit_sel,
    output logic [BCD_W*DIGITS-1:0]   value_out,
    output logic                      tick,
    output logic                      wrap
);

    localparam int                   IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [CMP_WIDTH-1:0] CMP_ONE  = CMP_WIDTH'(1);

    logic [CMP_WIDTH-1:0]    r_compare;
    logic [CMP_WIDTH-1:0]    r_presc;
    logic [CMP_WIDTH-1:0]    w_period;
    logic                    w_tick_due;
    logic [BCD_W*DIGITS-1:0] r_count;
    logic [BCD_W*DIGITS-1:0] w_count_next;
    logic                    w_carry;
    logic                    r_tick;
    logic                    r_wrap;
    logic [SCAN_DIV-1:0]     r_scan;
    logic [IDX_W-1:0]        r_idx;
    logic [DIGITS-1:0]       r_digit_sel;
    logic [SEG_W-1:0]        r_led;
    logic [SEG_W-1:0]        w_seg;
    logic [BCD_W-1:0]        w_cur_digit;

    // A zero period behaves as one so the prescaler never gets stuck.
    assign w_period   = (r_compare == '0) ? CMP_ONE : r_compare;
    assign w_tick_due = enable && (r_presc == w_period - CMP_ONE);

    // Ripple carry/borrow through the digits; w_carry out of the top is the wrap.
    always_comb begin
        w_count_next = r_count;
        w_carry      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                if (!count_down) begin
                    if (r_count[i*BCD_W +: BCD_W] == BCD_W'(9)) begin
                        w_count_next[i*BCD_W +: BCD_W] = '0;
                    end else begin
                        w_count_next[i*BCD_W +: BCD_W] = r_count[i*BCD_W +: BCD_W] + BCD_W'(1);
                        w_carry = 1'b0;
                    end
                end else begin
                    if (r_count[i*BCD_W +: BCD_W] == '0) begin
                        w_count_next[i*BCD_W +: BCD_W] = BCD_W'(9);
                    end else begin
                        w_count_next[i*BCD_W +: BCD_W] = r_count[i*BCD_W +: BCD_W] - BCD_W'(1);
                        w_carry = 1'b0;
                    end
                end
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_compare <= CMP_WIDTH'(DEFAULT_COMPARE);
            r_presc   <= '0;
            r_count   <= '0;
            r_tick    <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            if (clear) begin
                r_presc <= '0;
                r_count <= '0;
                if (update_compare) begin
                    r_compare <= compare_in;
                end
            end else if (update_compare) begin
                r_compare <= compare_in;
                r_presc   <= '0;
            end else if (w_tick_due) begin
                r_presc <= '0;
                r_count <= w_count_next;
                r_tick  <= 1'b1;
                r_wrap  <= w_carry;
            end else if (enable) begin
                r_presc <= r_presc + CMP_ONE;
            end
        end
    end

    assign w_cur_digit = r_count[BCD_W*int'(r_idx) +: BCD_W];

    seven_seg_decode u_decode (
        .i_bcd (w_cur_digit),
        .o_seg (w_seg)
    );

    // Select and segments are both registered from r_idx so they never skew.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scan      <= '0;
            r_idx       <= '0;
            r_digit_sel <= DIGITS'(1);
            r_led       <= SEG_TABLE[0];
        end else begin
            r_scan <= r_scan + SCAN_DIV'(1);
            if (&r_scan) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
            end
            r_digit_sel <= DIGITS'(1) << r_idx;
            r_led       <= w_seg;
        end
    end

    assign led_out   = r_led;
    assign digit_sel = r_digit_sel;
    assign value_out = r_count;
    assign tick      = r_tick;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_seven_segment_mux_counter.sv
// Directed bench for seven_segment_mux_counter: reload/tick spacing, BCD wrap
// and borrow, scan/decode order, control priority and asynchronous reset.
module tb_seven_segment_mux_counter;

    localparam int DIGITS          = 4;
    localparam int CMP_WIDTH       = 8;
    localparam int DEFAULT_COMPARE = 8;
    localparam int SCAN_DIV        = 2;

    localparam logic [6:0] SEG_1234 [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   enable;
    logic                   count_down;
    logic                   clear;
    logic                   update_compare;
    logic [CMP_WIDTH-1:0]   compare_in;
    logic [6:0]             led_out;
    logic [DIGITS-1:0]      digit_sel;
    logic [4*DIGITS-1:0]    value_out;
    logic                   tick;
    logic                   wrap;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    seven_segment_mux_counter #(
        .DIGITS          (DIGITS),
        .CMP_WIDTH       (CMP_WIDTH),
        .DEFAULT_COMPARE (DEFAULT_COMPARE),
        .SCAN_DIV        (SCAN_DIV)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .count_down     (count_down),
        .clear          (clear),
        .update_compare (update_compare),
        .compare_in     (compare_in),
        .led_out        (led_out),
        .digit_sel      (digit_sel),
        .value_out      (value_out),
        .tick           (tick),
        .wrap           (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic found;
        logic saw_tick;

        reset_n        = 1'b1;
        enable         = 1'b0;
        count_down     = 1'b0;
        clear          = 1'b0;
        update_compare = 1'b0;
        compare_in     = '0;

        // Reset values without any clock edge.
        #1 reset_n = 1'b0;
        #1;
        check("rst_led",   32'(led_out),   32'h3F);
        check("rst_sel",   32'(digit_sel), 32'h1);
        check("rst_value", 32'(value_out), 32'h0000);
        check("rst_tick",  32'(tick),      32'h0);
        check("rst_wrap",  32'(wrap),      32'h0);

        repeat (3) step();
        reset_n = 1'b1;
        enable  = 1'b1;

        // Default period: first tick after DEFAULT_COMPARE enabled edges.
        repeat (7) step();
        check("dflt_no_tick", 32'(tick), 32'h0);
        step();
        check("dflt_tick",  32'(tick),      32'h1);
        check("dflt_value", 32'(value_out), 32'h0001);

        // Reload with period 5.
        update_compare = 1'b1;
        compare_in     = 8'd5;
        step();
        check("upd_no_tick", 32'(tick), 32'h0);
        update_compare = 1'b0;
        repeat (4) step();
        check("p5_no_tick_a", 32'(tick), 32'h0);
        step();
        check("p5_tick_a",  32'(tick),      32'h1);
        check("p5_value_a", 32'(value_out), 32'h0002);
        repeat (4) step();
        check("p5_no_tick_b", 32'(tick), 32'h0);
        step();
        check("p5_tick_b",  32'(tick),      32'h1);
        check("p5_value_b", 32'(value_out), 32'h0003);

        // Clear, then compare 0 (tick every enabled cycle), down then up wrap.
        clear = 1'b1;
        step();
        check("clr_value", 32'(value_out), 32'h0000);
        check("clr_tick",  32'(tick),      32'h0);
        clear          = 1'b0;
        update_compare = 1'b1;
        compare_in     = 8'd0;
        step();
        check("upd0_no_tick", 32'(tick), 32'h0);
        update_compare = 1'b0;
        count_down     = 1'b1;
        step();
        check("dn_wrap_value", 32'(value_out), 32'h9999);
        check("dn_wrap_tick",  32'(tick),      32'h1);
        check("dn_wrap_wrap",  32'(wrap),      32'h1);
        count_down = 1'b0;
        step();
        check("up_wrap_value", 32'(value_out), 32'h0000);
        check("up_wrap_tick",  32'(tick),      32'h1);
        check("up_wrap_wrap",  32'(wrap),      32'h1);

        // Count up to 0100 then borrow down to 0099.
        repeat (100) step();
        check("up100_value", 32'(value_out), 32'h0100);
        check("up100_wrap",  32'(wrap),      32'h0);
        count_down = 1'b1;
        step();
        check("borrow_value", 32'(value_out), 32'h0099);
        check("borrow_tick",  32'(tick),      32'h1);
        check("borrow_wrap",  32'(wrap),      32'h0);

        // Reach 1234 and freeze it for the scan check.
        clear      = 1'b1;
        count_down = 1'b0;
        step();
        clear = 1'b0;
        repeat (1234) step();
        enable = 1'b0;
        check("scan_value", 32'(value_out), 32'h1234);

        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            step();
            if (digit_sel == 4'b1000) found = 1'b1;
        end
        check("scan_sync_last", 32'(found), 32'h1);
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            step();
            if (digit_sel == 4'b0001) found = 1'b1;
        end
        check("scan_sync_first", 32'(found), 32'h1);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                check($sformatf("scan_sel_d%0d_c%0d", k, j), 32'(digit_sel), 32'(1) << k);
                check($sformatf("scan_led_d%0d_c%0d", k, j), 32'(led_out),   32'(SEG_1234[k]));
                step();
            end
        end
        check("scan_sel_again", 32'(digit_sel), 32'h1);

        // Clear + update(3) + tick-due all in one cycle.
        enable         = 1'b1;
        clear          = 1'b1;
        update_compare = 1'b1;
        compare_in     = 8'd3;
        step();
        check("prio_value", 32'(value_out), 32'h0000);
        check("prio_tick",  32'(tick),      32'h0);
        check("prio_wrap",  32'(wrap),      32'h0);
        clear          = 1'b0;
        update_compare = 1'b0;
        repeat (2) step();
        check("prio_no_tick", 32'(tick), 32'h0);
        step();
        check("prio_tick3",  32'(tick),      32'h1);
        check("prio_value3", 32'(value_out), 32'h0001);

        // Asynchronous reset mid-count, away from any clock edge.
        repeat (2) step();
        #2 reset_n = 1'b0;
        #1;
        check("arst_value", 32'(value_out), 32'h0000);
        check("arst_led",   32'(led_out),   32'h3F);
        check("arst_sel",   32'(digit_sel), 32'h1);
        check("arst_tick",  32'(tick),      32'h0);
        check("arst_wrap",  32'(wrap),      32'h0);
        enable = 1'b0;
        step();
        reset_n  = 1'b1;
        saw_tick = 1'b0;
        repeat (20) begin
            step();
            if (tick) saw_tick = 1'b1;
        end
        check("arst_idle_no_tick", 32'(saw_tick), 32'h0);
        enable = 1'b1;
        repeat (7) step();
        check("arst_dflt_no_tick", 32'(tick), 32'h0);
        step();
        check("arst_dflt_tick",  32'(tick),      32'h1);
        check("arst_dflt_value", 32'(value_out), 32'h0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
